// File: rtl/lfsr_roll_pkg.sv
// Shared types and default constants for the LFSR roll sequencer.
package lfsr_roll_pkg;

  localparam int LFSR_W = 4;

  localparam logic [LFSR_W-1:0] LOCK_VAL_DEF   = 4'hF;
  localparam int                SPIN_MIN_DEF   = 8;
  localparam int                SLOW_START_DEF = 4;
  localparam int                SLOW_STEPS_DEF = 6;
  localparam int                CNT_W_DEF      = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPIN  = 3'd1,
    SLOW  = 3'd2,
    LATCH = 3'd3,
    SHOW  = 3'd4
  } state_t;

endpackage

// File: rtl/lfsr_roll_ctrl_if.sv
// Bundle between the roll sequencer (master) and the LFSR/7-seg datapath (slave).
//
// Signalling: lfsr_step and lfsr_clear are single-cycle commands that the
// datapath acts on at the next clock edge; they are never high together.
// result is meaningful only while result_valid is high; busy marks an active
// roll. state is the sequencer's current FSM state for observation.
interface lfsr_roll_ctrl_if import lfsr_roll_pkg::*; ();

  logic              roll_btn;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_step;
  logic              lfsr_clear;
  logic [LFSR_W-1:0] result;
  logic              result_valid;
  logic              busy;
  state_t            state;

  modport master (
    input  roll_btn, lfsr_q,
    output lfsr_step, lfsr_clear, result, result_valid, busy, state
  );

  modport slave (
    output roll_btn, lfsr_q,
    input  lfsr_step, lfsr_clear, result, result_valid, busy, state
  );

endinterface

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button plus a rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic s1, s2, s2_d;

  // Synchronizer chain plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s2_d;

endmodule

// File: rtl/lfsr_roll_ctrl.sv
// Roll sequencer: free-run the LFSR while the button is held, decelerate with
// doubling step intervals, then freeze and present the settled value. A step
// requested while the LFSR sits in its lock-up value becomes a clear instead.
module lfsr_roll_ctrl import lfsr_roll_pkg::*; #(
  parameter int                SPIN_MIN   = SPIN_MIN_DEF,
  parameter int                SLOW_START = SLOW_START_DEF,
  parameter int                SLOW_STEPS = SLOW_STEPS_DEF,
  parameter int                CNT_W      = CNT_W_DEF,
  parameter logic [LFSR_W-1:0] LOCK_VAL   = LOCK_VAL_DEF
) (
  input logic              clk,
  input logic              rst,
  lfsr_roll_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] SPIN_MIN_C   = CNT_W'(SPIN_MIN);
  localparam logic [CNT_W-1:0] SLOW_START_C = CNT_W'(SLOW_START);
  localparam logic [CNT_W-1:0] LAST_STEP_C  = CNT_W'(SLOW_STEPS - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CNT_W-1:0]  ivl, ivl_nx;
  logic [CNT_W-1:0]  wait_cnt, wait_nx;
  logic [CNT_W-1:0]  nsteps, nsteps_nx;
  logic [LFSR_W-1:0] result_r, result_nx;
  logic              valid_r, valid_nx;
  logic              step_req;
  logic              lock_hit;
  logic              btn_level, btn_rise;

  btn_sync_edge u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.roll_btn),
    .level (btn_level),
    .rise  (btn_rise)
  );

  // State, counters and held result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ivl      <= '0;
      wait_cnt <= '0;
      nsteps   <= '0;
      result_r <= '0;
      valid_r  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ivl      <= ivl_nx;
      wait_cnt <= wait_nx;
      nsteps   <= nsteps_nx;
      result_r <= result_nx;
      valid_r  <= valid_nx;
    end
  end

  // Next-state, counter updates and step request.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ivl_nx    = ivl;
    wait_nx   = wait_cnt;
    nsteps_nx = nsteps;
    result_nx = result_r;
    valid_nx  = valid_r;
    step_req  = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_rise) begin
          state_nx = SPIN;
          cnt_nx   = '0;
        end
      end
      SPIN: begin
        step_req = 1'b1;
        if (cnt != CNT_MAX) cnt_nx = cnt + 1'b1;
        // Early release is only honoured once the minimum spin has elapsed.
        if (cnt >= SPIN_MIN_C && !btn_level) begin
          state_nx  = SLOW;
          ivl_nx    = SLOW_START_C;
          wait_nx   = '0;
          nsteps_nx = '0;
        end
      end
      SLOW: begin
        if (wait_cnt == ivl - 1'b1) begin
          step_req  = 1'b1;
          wait_nx   = '0;
          nsteps_nx = nsteps + 1'b1;
          ivl_nx    = ivl[CNT_W-1] ? CNT_MAX : (ivl << 1);
          if (nsteps == LAST_STEP_C) state_nx = LATCH;
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end
      LATCH: begin
        // The final SLOW step has landed in the datapath by now.
        state_nx  = SHOW;
        result_nx = bus.lfsr_q;
        valid_nx  = 1'b1;
      end
      SHOW: begin
        if (btn_rise) begin
          state_nx = SPIN;
          cnt_nx   = '0;
          valid_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A step aimed at the lock-up value is replaced by a clear.
  assign lock_hit         = (bus.lfsr_q == LOCK_VAL);
  assign bus.lfsr_clear   = step_req & lock_hit;
  assign bus.lfsr_step    = step_req & ~lock_hit;
  assign bus.result       = result_r;
  assign bus.result_valid = valid_r;
  assign bus.busy         = (state == SPIN) || (state == SLOW) || (state == LATCH);
  assign bus.state        = state;

endmodule
